// File: rtl/csa_calc_sched_if.sv
// Dispatch/collect signal bundle between the calc-instance scheduler and its environment.
// The master modport is the scheduler side; slave is the upstream/instance side.
interface csa_calc_sched_if #(
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2
);
  logic                   job_valid;
  logic                   job_ready;
  logic [N-1:0]           inst_full;
  logic [N-1:0]           inst_wen;
  logic [INDEX_WIDTH-1:0] disp_index;
  logic [N-1:0]           inst_out_ready;
  logic [N-1:0]           inst_ren;
  logic                   coll_valid;
  logic [INDEX_WIDTH-1:0] coll_index;
  logic                   coll_done;

  modport master (
    input  job_valid, inst_full, inst_out_ready, coll_done,
    output job_ready, inst_wen, disp_index, inst_ren, coll_valid, coll_index
  );

  modport slave (
    output job_valid, inst_full, inst_out_ready, coll_done,
    input  job_ready, inst_wen, disp_index, inst_ren, coll_valid, coll_index
  );
endinterface

// File: rtl/csa_calc_sched.sv
// Round-robin job dispatcher and result collector for N calc instances with per-instance credit.
// Define CSA_CALC_SCHED_STATS_EN to build the 32-bit dispatch/collect statistics counters.
module csa_calc_sched #(
  parameter int CSA_CALC_INST_NUM = 4,
  parameter int INDEX_WIDTH       = 2,
  parameter int MAX_INFLIGHT      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CSA_CALC_INST_NUM-1:0] enable_mask,
  csa_calc_sched_if.master             bus,
  output logic                         idle,
  output logic [31:0]                  disp_count,
  output logic [31:0]                  coll_count
);
  localparam int N  = CSA_CALC_INST_NUM;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {C_SCAN, C_READ, C_HOLD} coll_state_e;

  coll_state_e            state;
  logic [INDEX_WIDTH-1:0] disp_ptr;
  logic [INDEX_WIDTH-1:0] coll_ptr;
  logic [INDEX_WIDTH-1:0] sel;
  logic [INDEX_WIDTH:0]   rr_sum;
  logic [CW-1:0]          inflight [N];
  logic [N-1:0]           eligible;
  logic                   any_eligible;
  logic                   wen_pending;
  logic                   accept;
  logic                   all_empty;

  function automatic logic [INDEX_WIDTH-1:0] next_index(input logic [INDEX_WIDTH-1:0] idx);
    return (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eligible  = '0;
    all_empty = 1'b1;
    for (int i = 0; i < N; i++) begin
      eligible[i] = enable_mask[i] & ~bus.inst_full[i] & (inflight[i] < CW'(MAX_INFLIGHT));
      if (inflight[i] != '0) all_empty = 1'b0;
    end
  end

  // Walk from the farthest offset back to disp_ptr so the nearest eligible index wins.
  always_comb begin
    sel          = disp_ptr;
    any_eligible = 1'b0;
    rr_sum       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_sum = {1'b0, disp_ptr} + (INDEX_WIDTH+1)'(k);
      if (rr_sum >= (INDEX_WIDTH+1)'(N)) rr_sum = rr_sum - (INDEX_WIDTH+1)'(N);
      if (eligible[rr_sum[INDEX_WIDTH-1:0]]) begin
        sel          = rr_sum[INDEX_WIDTH-1:0];
        any_eligible = 1'b1;
      end
    end
  end

  // rst_n gates acceptance so nothing can be handed over while the block is held in reset.
  assign wen_pending   = |bus.inst_wen;
  assign accept        = rst_n & bus.job_valid & any_eligible & ~wen_pending;
  assign bus.job_ready = accept;
  assign idle          = all_empty & (state == C_SCAN) & ~wen_pending;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.inst_wen   <= '0;
      bus.disp_index <= '0;
      disp_ptr       <= '0;
    end else begin
      bus.inst_wen <= '0;
      if (accept) begin
        bus.inst_wen   <= N'(1) << sel;
        bus.disp_index <= sel;
        disp_ptr       <= next_index(sel);
      end
    end
  end

  // A same-cycle write and read cancel; a read with nothing in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) inflight[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.inst_wen[i] && !bus.inst_ren[i] && inflight[i] < CW'(MAX_INFLIGHT))
          inflight[i] <= inflight[i] + 1'b1;
        else if (bus.inst_ren[i] && !bus.inst_wen[i] && inflight[i] != '0)
          inflight[i] <= inflight[i] - 1'b1;
      end
    end
  end

  // Collect FSM: enable_mask is deliberately ignored here so disabled instances still drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= C_SCAN;
      coll_ptr       <= '0;
      bus.inst_ren   <= '0;
      bus.coll_valid <= 1'b0;
      bus.coll_index <= '0;
    end else begin
      bus.inst_ren <= '0;
      case (state)
        C_SCAN: begin
          if (bus.inst_out_ready[coll_ptr]) begin
            state          <= C_READ;
            bus.inst_ren   <= N'(1) << coll_ptr;
            bus.coll_index <= coll_ptr;
          end else begin
            coll_ptr <= next_index(coll_ptr);
          end
        end
        C_READ: begin
          state          <= C_HOLD;
          bus.coll_valid <= 1'b1;
        end
        C_HOLD: begin
          if (bus.coll_done) begin
            state          <= C_SCAN;
            bus.coll_valid <= 1'b0;
            coll_ptr       <= next_index(coll_ptr);
          end
        end
        default: state <= C_SCAN;
      endcase
    end
  end

`ifdef CSA_CALC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_count <= '0;
      coll_count <= '0;
    end else begin
      if (accept)           disp_count <= disp_count + 32'd1;
      if (|bus.inst_ren)    coll_count <= coll_count + 32'd1;
    end
  end
`else
  assign disp_count = '0;
  assign coll_count = '0;
`endif

endmodule

// File: tb/tb_csa_calc_sched.sv
// Self-checking bench for csa_calc_sched: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of dispatch, credit and collection.
module tb_csa_calc_sched;
  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int MAXI = 4;
  localparam int ST_SCAN = 0, ST_READ = 1, ST_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [N-1:0] enable_mask;
  logic        idle;
  logic [31:0] disp_count, coll_count;

  csa_calc_sched_if #(.N(N), .INDEX_WIDTH(IW)) bus ();

  csa_calc_sched #(.CSA_CALC_INST_NUM(N), .INDEX_WIDTH(IW), .MAX_INFLIGHT(MAXI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_mask (enable_mask),
    .bus         (bus),
    .idle        (idle),
    .disp_count  (disp_count),
    .coll_count  (coll_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int wen_log[$], wen_cyc[$], ren_log[$];

  // Reference model state: plain integers, -1 meaning "no pulse".
  int m_wen, m_dindex, m_dptr, m_stage, m_cptr, m_cindex;
  int m_infl[N];
  int unsigned m_dcnt, m_ccnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned stat_exp(input int unsigned v);
`ifdef CSA_CALC_SCHED_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int one_hot(input int idx);
    return (idx >= 0) ? (1 << idx) : 0;
  endfunction

  task automatic model_reset();
    m_wen = -1; m_dindex = 0; m_dptr = 0; m_stage = ST_SCAN; m_cptr = 0; m_cindex = 0;
    m_dcnt = 0; m_ccnt = 0;
    for (int i = 0; i < N; i++) m_infl[i] = 0;
  endtask

  // Called at a negedge: check registered outputs, apply inputs, check job_ready, advance model.
  task automatic cycle(input logic jv, input logic [N-1:0] en, input logic [N-1:0] full,
                       input logic [N-1:0] ordy, input logic cd);
    int  tgt, ren_i, total;
    bit  exp_ready, inc, dec;
    bit  elig[N];
    total = 0;
    for (int i = 0; i < N; i++) total += m_infl[i];
    ren_i = (m_stage == ST_READ) ? m_cptr : -1;
    check("inst_wen",   32'(bus.inst_wen),   one_hot(m_wen));
    check("disp_index", 32'(bus.disp_index), m_dindex);
    check("inst_ren",   32'(bus.inst_ren),   one_hot(ren_i));
    check("coll_valid", 32'(bus.coll_valid), (m_stage == ST_HOLD) ? 1 : 0);
    check("coll_index", 32'(bus.coll_index), m_cindex);
    check("idle",       32'(idle), (total == 0 && m_stage == ST_SCAN && m_wen < 0) ? 1 : 0);
    check("disp_count", disp_count, stat_exp(m_dcnt));
    check("coll_count", coll_count, stat_exp(m_ccnt));
    for (int i = 0; i < N; i++) if (bus.inst_wen[i]) begin wen_log.push_back(i); wen_cyc.push_back(cyc); end
    for (int i = 0; i < N; i++) if (bus.inst_ren[i]) ren_log.push_back(i);

    bus.job_valid = jv; enable_mask = en; bus.inst_full = full;
    bus.inst_out_ready = ordy; bus.coll_done = cd;
    #1;
    tgt = -1;
    for (int i = 0; i < N; i++) elig[i] = en[i] && !full[i] && (m_infl[i] < MAXI);
    for (int k = 0; k < N; k++) if (tgt < 0 && elig[(m_dptr + k) % N]) tgt = (m_dptr + k) % N;
    exp_ready = jv && (m_wen < 0) && (tgt >= 0);
    check("job_ready", 32'(bus.job_ready), exp_ready);

    for (int i = 0; i < N; i++) begin
      inc = (m_wen == i);
      dec = (ren_i == i);
      if (inc && !dec && m_infl[i] < MAXI) m_infl[i]++;
      else if (dec && !inc && m_infl[i] > 0) m_infl[i]--;
    end
    if (ren_i >= 0) m_ccnt++;
    if (exp_ready) begin
      m_wen = tgt; m_dindex = tgt; m_dptr = (tgt + 1) % N; m_dcnt++;
    end else begin
      m_wen = -1;
    end
    case (m_stage)
      ST_SCAN: if (ordy[m_cptr]) begin m_stage = ST_READ; m_cindex = m_cptr; end
               else m_cptr = (m_cptr + 1) % N;
      ST_READ: m_stage = ST_HOLD;
      default: if (cd) begin m_stage = ST_SCAN; m_cptr = (m_cptr + 1) % N; end
    endcase
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between edges with a job offered, checks the immediate effect, then releases.
  task automatic do_reset();
    bus.job_valid = 1'b1; enable_mask = '1; bus.inst_full = '0;
    bus.inst_out_ready = '0; bus.coll_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_inst_wen",   32'(bus.inst_wen), 0);
    check("rst_inst_ren",   32'(bus.inst_ren), 0);
    check("rst_disp_index", 32'(bus.disp_index), 0);
    check("rst_coll_valid", 32'(bus.coll_valid), 0);
    check("rst_coll_index", 32'(bus.coll_index), 0);
    check("rst_job_ready",  32'(bus.job_ready), 0);
    check("rst_idle",       32'(idle), 1);
    check("rst_counts",     disp_count | coll_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.job_valid = 1'b0;
    wen_log.delete(); wen_cyc.delete(); ren_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int age, n;
    rst_n = 1'b0; enable_mask = '0;
    bus.job_valid = 1'b0; bus.inst_full = '0; bus.inst_out_ready = '0; bus.coll_done = 1'b0;
    model_reset();
    @(negedge clk);

    // All enabled, none full: strict 0..3 rotation, one write every 2 cycles.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    check("rr_count", wen_log.size(), 8);
    for (int i = 0; i < wen_log.size() && i < 8; i++) begin
      check("rr_target", wen_log[i], i % 4);
      if (i > 0) check("rr_spacing", wen_cyc[i] - wen_cyc[i-1], 2);
    end

    // Full and disabled instances are skipped.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'b1011, 4'b0010, 4'b0000, 1'b0);
    check("skip_count", wen_log.size(), 4);
    for (int i = 0; i < wen_log.size() && i < 4; i++) check("skip_target", wen_log[i], (i % 2 == 0) ? 0 : 3);

    // Credit exhaustion: 16 jobs then stall; one result from instance 2 frees exactly one slot there.
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    check("credit_total", wen_log.size(), 16);
    wen_log.delete();
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 4'b1111, 4'b0000, (ren_log.size() == 0) ? 4'b0100 : 4'b0000, bus.coll_valid);
    check("credit_ren_count", ren_log.size(), 1);
    if (ren_log.size() > 0) check("credit_ren_index", ren_log[0], 2);
    check("credit_refill_count", wen_log.size(), 1);
    if (wen_log.size() > 0) check("credit_refill_target", wen_log[0], 2);

    // Collection with a drain acknowledged 3 cycles after each hold entry.
    do_reset();
    age = 0;
    for (int i = 0; i < 30; i++) begin
      age = bus.coll_valid ? age + 1 : 0;
      cycle(1'b0, 4'b1111, 4'b0000, 4'b1001, age == 4);
    end
    check("coll_order_count", ren_log.size() >= 2, 1);
    if (ren_log.size() >= 2) begin
      check("coll_first", ren_log[0], 0);
      check("coll_second", ren_log[1], 3);
    end

    // Simultaneous write and read on instance 1 with two jobs in flight, then reset mid-hold.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(i % 2 == 0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    n = 0;
    while (n < 12 && !(m_stage == ST_SCAN && m_cptr == 1 && m_wen < 0)) begin
      cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
      n++;
    end
    cycle(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0);
    check("same_cycle_wen", 32'(bus.inst_wen), 32'h2);
    check("same_cycle_ren", 32'(bus.inst_ren), 32'h2);
    cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    wen_log.delete();
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    check("same_cycle_refill", wen_log.size(), 2);
    check("hold_before_reset", 32'(bus.coll_valid), 1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // Statistics: 5 accepted jobs, 3 reads.
    do_reset();
    for (int i = 0; i < 40; i++)
      cycle(wen_log.size() < 5, 4'b1111, 4'b0000,
            (ren_log.size() < 3) ? 4'b1111 : 4'b0000, bus.coll_valid);
    check("stats_wen", wen_log.size(), 5);
    check("stats_ren", ren_log.size(), 3);
    check("stats_disp_count", disp_count, stat_exp(5));
    check("stats_coll_count", coll_count, stat_exp(3));

    // Random traffic against the model, with one reset partway through.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111,
            N'($urandom & $urandom & $urandom),
            N'($urandom),
            $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/csa_calc_sched.md
CSA_CALC_SCHED -- requirements
Module: csa_calc_sched

Interface
REQ-001 SHALL have parameter CSA_CALC_INST_NUM, default 4, number of calc instances scheduled (2..16).
REQ-002 SHALL have parameter INDEX_WIDTH, default 2, width of instance indices (>= clog2(CSA_CALC_INST_NUM)).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, per-instance limit on jobs dispatched and not yet collected.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable_mask  in  N  per-instance enable; 0 excludes the instance from dispatch.
- job_valid  in  1  a job descriptor is present upstream.
- job_ready  out  1  the job is accepted this cycle.
- inst_full  in  N  per-instance input FIFO full.
- inst_wen  out  N  one-hot write pulse to the selected instance.
- disp_index  out  INDEX_WIDTH  index of the last dispatched instance.
- inst_out_ready  in  N  per-instance result available.
- inst_ren  out  N  one-hot read pulse to the selected instance.
- coll_valid  out  1  a collected result is held for draining.
- coll_index  out  INDEX_WIDTH  instance of the held result.
- coll_done  in  1  downstream drain finished, one-cycle pulse.
- idle  out  1  no jobs in flight and both FSMs idle.
- disp_count, coll_count  out  32 each  statistics (macro-dependent).

Function
REQ-005 SHALL treat instance i as dispatch-eligible when enable_mask[i]=1, inst_full[i]=0 and inflight[i] < MAX_INFLIGHT.
REQ-006 SHALL drive job_ready combinationally high iff job_valid=1, at least one instance is eligible, and no inst_wen pulse is pending this cycle.
REQ-007 SHALL select the dispatch target round-robin: the first eligible index at or after disp_ptr, wrapping from N-1 to 0.
REQ-008 SHALL, on job_valid & job_ready in cycle T, assert inst_wen[sel] for exactly cycle T+1, load disp_index=sel at T+1, and set disp_ptr to sel+1, wrapping to 0.
REQ-009 SHALL sustain at most one dispatch every 2 cycles, because job_ready is low during the inst_wen cycle.
REQ-010 SHALL run the collect FSM with states C_SCAN, C_READ and C_HOLD.
REQ-011 In C_SCAN, SHALL test inst_out_ready[coll_ptr]; if it is 1, go to C_READ, otherwise advance coll_ptr by 1, wrapping.
REQ-012 In C_READ, SHALL pulse inst_ren[coll_ptr] for one cycle, set coll_index=coll_ptr, and go to C_HOLD.
REQ-013 In C_HOLD, SHALL hold coll_valid=1.
REQ-014 On coll_done in C_HOLD, SHALL clear coll_valid the next cycle, advance coll_ptr by 1, and return to C_SCAN.
REQ-015 SHALL ignore coll_done outside C_HOLD.
REQ-016 SHALL keep a per-instance inflight counter:
- +1 on inst_wen[i];
- -1 on inst_ren[i];
- both in the same cycle: unchanged;
- never wraps below 0 (a decrement at 0 is ignored) and never exceeds MAX_INFLIGHT.
REQ-017 SHALL collect from instances whose enable_mask bit is 0, so in-flight jobs always drain.
REQ-018 SHALL drive idle=1 iff all inflight counters are 0, the collect FSM is in C_SCAN, and no inst_wen pulse is pending.
REQ-019 SHALL never assert more than one bit of inst_wen, or more than one bit of inst_ren, in any cycle.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force the following to 0:
- inst_wen, inst_ren, disp_index, coll_valid, coll_index;
- disp_ptr, coll_ptr, all inflight counters;
- disp_count, coll_count.
REQ-021 SHALL place the collect FSM in C_SCAN while rst_n=0.
REQ-022 SHALL, when reset asserts mid-dispatch or mid-hold, drop pending pulses and coll_valid immediately, with no completion afterwards.
REQ-023 SHALL, while rst_n=0, hold job_ready=0 and idle=1.

Configuration
REQ-024 With macro CSA_CALC_SCHED_STATS_EN defined:
- disp_count SHALL increment on each accepted job;
- coll_count SHALL increment on each inst_ren pulse;
- both SHALL be 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-025 Without CSA_CALC_SCHED_STATS_EN, disp_count and coll_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-026 All enabled, none full, job_valid held for 8 jobs -> inst_wen sequence 0,1,2,3,0,1,2,3, one pulse every 2 cycles, disp_index tracking.
REQ-027 inst_full=4'b0010, enable_mask=4'b1011, 4 jobs -> targets 0,3,0,3; instances 1 and 2 never written.
REQ-028 No collection, MAX_INFLIGHT=4, N=4 -> exactly 16 jobs accepted, then job_ready stays 0. One result from instance 2 collected -> the next job goes to instance 2.
REQ-029 inst_out_ready=4'b1001, coll_done 3 cycles after each C_HOLD entry -> inst_ren[0] then inst_ren[3]; coll_valid high exactly until the cycle after each coll_done.
REQ-030 inst_wen[1] and inst_ren[1] in the same cycle with inflight[1]=2 -> inflight[1] stays 2. Then rst_n low for 1 cycle during C_HOLD -> all outputs 0, idle=1 immediately.
REQ-031 With CSA_CALC_SCHED_STATS_EN: 5 dispatches, 3 collects -> disp_count=5, coll_count=3. Without the macro -> both read 0.
